// File: rtl/pipe_pkg.sv
// Shared defaults and control-bundle layout for the inter-stage pipeline latches.
package pipe_pkg;

  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DATA_W = 8;

  // Bit offsets of the packed control bundle (MSB first).
  localparam int CTRL_RA_BIT     = 7;
  localparam int CTRL_RB_BIT     = 6;
  localparam int CTRL_RW_BIT     = 5;
  localparam int CTRL_SP_BIT     = 4;
  localparam int CTRL_SW1_BIT    = 3;
  localparam int CTRL_SW2_BIT    = 2;
  localparam int CTRL_OUT_LD_BIT = 1;
  localparam int CTRL_HLT_BIT    = 0;

  localparam logic [DEF_CTRL_W-1:0] DEF_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One latch entry (ctrl, data, valid): clear beats load, otherwise hold.
// Latency 1 cycle; no flow control of its own, the parent decides load/clear.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                 CTRL_W   = DEF_CTRL_W,
  parameter int                 DATA_W   = DEF_DATA_W,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = DEF_CTRL_NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              clear_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic              q_valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_NOP;
      q_data  <= '0;
    end else if (clear) begin
      // Data survives a clear unless asked otherwise, so bubbles keep old data.
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_NOP;
      if (clear_data) q_data <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_latch_skid.sv
// Pipeline-stage latch with 2-entry skid buffer; 1-cycle latency, full throughput.
// in_ready comes straight from the skid-valid flop, so a stall never loses an instruction.
module pipe_latch_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                CTRL_W     = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_NOP   = DEF_CTRL_NOP,
  parameter bit                FLUSH_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        occupancy
);

  logic              m_vld, s_vld;
  logic [CTRL_W-1:0] s_ctrl, m_d_ctrl;
  logic [DATA_W-1:0] s_data, m_d_data;
  logic              m_load, m_clear, m_clear_data;
  logic              s_load, s_clear, s_clear_data;
  logic              push, pop;

  assign in_ready  = ~s_vld;
  assign push      = in_valid & in_ready;
  assign pop       = m_vld & out_ready;
  assign out_valid = m_vld;
  assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};

  always_comb begin
    m_load       = 1'b0;
    m_clear      = 1'b0;
    m_clear_data = 1'b0;
    s_load       = 1'b0;
    s_clear      = 1'b0;
    s_clear_data = 1'b0;
    m_d_ctrl     = in_ctrl;
    m_d_data     = in_data;
    if (flush) begin
      m_clear      = 1'b1;
      s_clear      = 1'b1;
      m_clear_data = FLUSH_DATA;
      s_clear_data = FLUSH_DATA;
    end else if (!m_vld || pop) begin
      if (s_vld) begin
        // in_ready is low here, so no push can collide with the skid transfer.
        m_load   = 1'b1;
        m_d_ctrl = s_ctrl;
        m_d_data = s_data;
        s_clear  = 1'b1;
      end else if (push) begin
        m_load = 1'b1;
      end else begin
        m_clear = 1'b1;
      end
    end else if (push) begin
      s_load = 1'b1;
    end
  end

  pipe_entry_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .load       (m_load),
    .clear      (m_clear),
    .clear_data (m_clear_data),
    .d_ctrl     (m_d_ctrl),
    .d_data     (m_d_data),
    .q_ctrl     (ctrl),
    .q_data     (data),
    .q_valid    (m_vld)
  );

  pipe_entry_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (s_load),
    .clear      (s_clear),
    .clear_data (s_clear_data),
    .d_ctrl     (in_ctrl),
    .d_data     (in_data),
    .q_ctrl     (s_ctrl),
    .q_data     (s_data),
    .q_valid    (s_vld)
  );

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Bench for pipe_latch_skid: queue scoreboard plus per-scenario directed checks.
module tb_pipe_latch_skid;

  localparam logic [7:0] NOP = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ctrl = 8'h00;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid;
  logic [7:0] ctrl, data;
  logic [1:0] occupancy;

  logic       in_ready0, out_valid0;
  logic [7:0] ctrl0, data0;
  logic [1:0] occupancy0;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] d;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_latch_skid #(.DATA_W(8), .CTRL_W(8), .CTRL_NOP(NOP), .FLUSH_DATA(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl(ctrl), .data(data), .occupancy(occupancy)
  );

  pipe_latch_skid #(.DATA_W(8), .CTRL_W(8), .CTRL_NOP(NOP), .FLUSH_DATA(1'b0)) dut_hold (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .ctrl(ctrl0), .data(data0), .occupancy(occupancy0)
  );

  // Scoreboard: observe handshakes mid-cycle, pop on consume, push on accept.
  always @(negedge clk) begin
    ent_t e;
    if (!reset) begin
      q.delete();
    end else begin
      checks++;
      if (int'(occupancy) !== q.size()) begin
        failures++;
        $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, q.size());
      end
      checks++;
      if (int'(occupancy0) !== q.size()) begin
        failures++;
        $display("FAIL sb_occupancy_hold: got %0d expected %0d", occupancy0, q.size());
      end
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        failures++;
        $display("FAIL sb_out_valid: got %b expected %b", out_valid, q.size() != 0);
      end
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL sb_in_ready: got %b expected %b", in_ready, q.size() < 2);
      end
      if (!out_valid) begin
        checks++;
        if (ctrl !== NOP) begin
          failures++;
          $display("FAIL sb_idle_ctrl: got %h expected %h", ctrl, NOP);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_out: ctrl %h data %h with empty scoreboard", ctrl, data);
        end else begin
          e = q.pop_front();
          if (ctrl !== e.c || data !== e.d) begin
            failures++;
            $display("FAIL sb_out: got ctrl %h data %h expected ctrl %h data %h", ctrl, data, e.c, e.d);
          end
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{c: in_ctrl, d: in_data});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_two(input logic [7:0] c1, input logic [7:0] d1,
                          input logic [7:0] c2, input logic [7:0] d2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = c1; in_data = d1;
    cyc();
    in_ctrl = c2; in_data = d2;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ctrl !== NOP || data !== 8'h00 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: out_valid %b ctrl %h data %h in_ready %b occ %0d, expected 0 %h 00 1 0",
               out_valid, ctrl, data, in_ready, occupancy, NOP);
    end
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_flow();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 8'h11;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ctrl !== 8'h5A || data !== 8'h11 || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL flow_first: out_valid %b ctrl %h data %h occ %0d, expected 1 5a 11 1",
               out_valid, ctrl, data, occupancy);
    end
    cyc();
    cyc();
  endtask

  task automatic test_stall_fill();
    fill_two(8'hA1, 8'h21, 8'hA2, 8'h22);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || ctrl !== 8'hA1 || data !== 8'h21) begin
      failures++;
      $display("FAIL stall_full: occ %0d in_ready %b ctrl %h data %h, expected 2 0 a1 21",
               occupancy, in_ready, ctrl, data);
    end
    in_valid = 1'b1; in_ctrl = 8'hA3; in_data = 8'h23;
    cyc();
    cyc();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || ctrl !== 8'hA1 || data !== 8'h21) begin
      failures++;
      $display("FAIL stall_hold: occ %0d ctrl %h data %h, expected 2 a1 21", occupancy, ctrl, data);
    end
  endtask

  task automatic test_drain();
    checks++;
    if (ctrl !== 8'hA1) begin
      failures++;
      $display("FAIL drain_0: ctrl %h expected a1", ctrl);
    end
    out_ready = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b1 || ctrl !== 8'hA2 || data !== 8'h22 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_1: out_valid %b ctrl %h data %h in_ready %b, expected 1 a2 22 1",
               out_valid, ctrl, data, in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0 || ctrl !== NOP || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL drain_2: out_valid %b ctrl %h occ %0d, expected 0 %h 0", out_valid, ctrl, occupancy, NOP);
    end
    cyc();
  endtask

  task automatic test_flush();
    fill_two(8'hC1, 8'h33, 8'hC2, 8'h44);
    flush = 1'b1;
    in_valid = 1'b1; in_ctrl = 8'hB0; in_data = 8'h55;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || ctrl !== NOP || data !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear: occ %0d out_valid %b ctrl %h data %h in_ready %b, expected 0 0 %h 00 1",
               occupancy, out_valid, ctrl, data, in_ready, NOP);
    end
    checks++;
    if (occupancy0 !== 2'd0 || ctrl0 !== NOP || data0 !== 8'h33) begin
      failures++;
      $display("FAIL flush_hold_data: occ %0d ctrl %h data %h, expected 0 %h 33", occupancy0, ctrl0, data0, NOP);
    end
    cyc();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard: occ %0d out_valid %b, expected 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_async_reset();
    fill_two(8'hD1, 8'h66, 8'hD2, 8'h77);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ctrl !== NOP || data !== 8'h00 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: out_valid %b ctrl %h data %h in_ready %b occ %0d, expected 0 %h 00 1 0",
               out_valid, ctrl, data, in_ready, occupancy, NOP);
    end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_ctrl = 8'(i);
      in_data = 8'(i) ^ 8'hFF;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: in_ready %b expected 1", i, in_ready);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || ctrl !== 8'(i) || data !== (8'(i) ^ 8'hFF) || occupancy !== 2'd1) begin
        failures++;
        $display("FAIL b2b_out[%0d]: out_valid %b ctrl %h data %h occ %0d, expected 1 %h %h 1",
                 i, out_valid, ctrl, data, occupancy, 8'(i), 8'(i) ^ 8'hFF);
      end
    end
    in_valid = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL b2b_empty: out_valid %b occ %0d, expected 0 0", out_valid, occupancy);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_flow();
    test_stall_fill();
    test_drain();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_latch_skid.md
Name: pipe_latch_skid

Overview:
- Generic, parametrised pipeline-stage latch. Successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/M, M/WB).
- Carries a control bundle and a data bundle between stages using a valid/ready handshake instead of a bare load enable.
- A 2-entry skid buffer means the upstream stage never loses an instruction when the downstream stage stalls. Ready is driven directly from a flop, which breaks the combinational stall path.
- Flush inserts a bubble whose control field is forced to a configurable no-op value.

Parameters:
- DATA_W, 8: width of the data bundle (e.g. DataOut, immediates).
- CTRL_W, 8: width of the control bundle (ra, rb, RW, SP, SW1, SW2, out_ld, Hlt packed).
- CTRL_NOP, 0: control value presented whenever the stage holds no valid instruction, and the value loaded on flush.
- FLUSH_DATA, 1: 1 = data fields cleared to 0 on flush/reset; 0 = data held on flush (reset always clears).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous kill of all held entries.
- in_valid, input, 1: upstream presents an instruction.
- in_ready, output, 1: stage can accept; registered.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: main entry holds a valid instruction.
- out_ready, input, 1: downstream consumes the main entry this cycle.
- ctrl, output, CTRL_W: main-entry control; CTRL_NOP when out_valid=0.
- data, output, DATA_W: main-entry data.
- occupancy, output, 2: number of valid entries (0..2).

Behaviour:
- Storage:
  - Main entry M (ctrl, data, mv); skid entry S (ctrl, data, sv).
  - Outputs are driven straight from M; no combinational in-to-out path.
- Handshake:
  - push = in_valid & in_ready; pop = mv & out_ready.
  - in_ready = !sv, taken from the flop only.
  - occupancy = mv + sv.
- Reset (async, reset=0):
  - mv=sv=0; M.ctrl=S.ctrl=CTRL_NOP; M.data=S.data=0.
  - Outputs: out_valid=0, ctrl=CTRL_NOP, data=0, in_ready=1, occupancy=0.
  - Reset mid-operation drops both entries immediately.
- Invariant: sv=1 implies mv=1.
- Priority per clock: reset > flush > normal update.
- Flush:
  - mv<=0, sv<=0, both ctrl<=CTRL_NOP.
  - Data <=0 if FLUSH_DATA=1, otherwise held.
  - A simultaneous push is discarded; a simultaneous pop is still counted by downstream (it saw out_valid=1 that cycle).
  - in_ready=1 on the following cycle.
- Normal update, when !mv or pop (M free or freeing):
  - If sv: M<=S, sv<=0, mv<=1. No push is possible (in_ready=0).
  - Else if push: M<=in, mv<=1.
  - Else: mv<=0, M.ctrl<=CTRL_NOP, M.data held (bubble).
- Normal update, when mv & !pop (downstream stalled):
  - If push: S<=in, sv<=1, so in_ready drops next cycle.
  - Else: hold.
- Latency:
  - 1 cycle in_valid to out_valid when empty.
  - Full throughput (1/cycle) while out_ready=1.
- Boundary cases:
  - Full (occupancy=2): in_ready=0; in_valid ignored without loss.
  - Pop while full: S moves to M; in_ready returns to 1 the next cycle.
  - Push and pop at occupancy=1: M replaced by new input; occupancy stays 1.
  - Stalled output (out_valid=1, out_ready=0): ctrl and data must stay stable.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W, DATA_W defaults.
  - Packed control-bundle field offsets (RA, RB, RW, SP, SW1, SW2, OUT_LD, HLT).
  - CTRL_NOP constant.
- One sub-module pipe_entry_reg:
  - A single entry (ctrl, data, valid) with load, clear and hold, plus async reset.
  - Instantiated twice (M, S).

Test Plan:
- Reset then flow: reset low, then high; in_valid=1, in_ctrl=8'h5A, in_data=8'h11; out_ready=1 -> next cycle out_valid=1, ctrl=8'h5A, data=8'h11, occupancy=1.
- Stall fill: out_ready=0; push 8'hA1, then 8'hA2 -> occupancy=2, in_ready=0, ctrl=8'hA1 held. Third push 8'hA3 is not accepted.
- Drain: from full, out_ready=1 for 3 cycles, in_valid=0 -> ctrl sequence A1, A2, then CTRL_NOP with out_valid=0; in_ready=1 after the first pop.
- Flush with push: occupancy=2, flush=1 together with in_valid=1 (8'hB0) -> next cycle occupancy=0, ctrl=CTRL_NOP. Data=0 with FLUSH_DATA=1; data held with FLUSH_DATA=0. 8'hB0 is discarded.
- Async reset mid-stall: occupancy=2, drop reset between clock edges -> outputs go to reset values immediately, without waiting for clk.
- Throughput: out_ready=1; push 16 values 0..15 back-to-back -> outputs 0..15 on consecutive cycles, with in_ready=1 throughout.
